uart_rx: RTL
============

# uart_rx

Serial receive stage for the pc_one SoC, the input-side counterpart of the existing UART transmitter. It deserialises 8N1 frames from the FPGA RX pin, buffers completed bytes in a small FIFO, and presents a pop interface plus status flags to the MMU. The MMU maps it at 0x00004008 (RX data, read pops) and 0x0000400C (RX status).

## Interface
- CLKS_PER_BIT, 868, clock cycles per bit (100 MHz / 115200 baud); must be ≥ 4.
- FIFO_DEPTH, 4, byte entries; power of two, ≥ 2.

- clk  in  1  system clock, 100 MHz; all logic on the rising edge.
- rst  in  1  synchronous, active-low reset.
- rx  in  1  asynchronous serial line; idles high.
- read_en  in  1  pop request from the MMU; ignored when the FIFO is empty.
- clear_errors  in  1  single-cycle pulse that clears `overrun` and `frame_error`.
- data  out  8  head-of-FIFO byte (show-ahead); 8'h00 when empty.
- rx_ready  out  1  FIFO not empty.
- fifo_full  out  1  FIFO holds FIFO_DEPTH bytes.
- overrun  out  1  sticky: a good byte was dropped because the FIFO was full.
- frame_error  out  1  sticky: a stop bit was sampled low.

## Operation
- Input: `rx` passes through a 2-flop synchroniser. All decisions use the synchronised value `rx_s`.
- Receive FSM states: IDLE, START, DATA, STOP. One baud counter and one 3-bit bit index are used.
  - IDLE: when `rx_s` = 0, load the counter and go to START.
  - START: wait CLKS_PER_BIT/2 cycles, then re-sample `rx_s`.
    - If `rx_s` = 0: go to DATA.
    - If `rx_s` = 1 (glitch): return to IDLE with no other effect.
  - DATA: every CLKS_PER_BIT cycles, sample `rx_s` into the shift register, LSB first. After bit 7, go to STOP.
  - STOP: wait CLKS_PER_BIT cycles, then sample `rx_s`.
    - If 1: push the byte into the FIFO.
    - If 0: discard the byte and set `frame_error`.
    - In both cases return to IDLE in the same cycle. Because the stop bit is sampled at its midpoint, a back-to-back start bit is caught.
- FIFO: a circular buffer with read and write pointers and a count of width log2(FIFO_DEPTH)+1. Pointers wrap modulo FIFO_DEPTH.
  - Push while full, no pop: byte dropped, `overrun` set, contents unchanged.
  - Push and pop in the same cycle while full: both take effect, count is unchanged, no overrun.
  - Push and pop in the same cycle while empty: only the push takes effect (pop is ignored).
  - Pop while empty: no effect. Pointers never move past the data.
- Error flags: if `clear_errors` and a new error event occur in the same cycle, the set wins.
- Reset (`rst` = 0 at an edge), including mid-frame:
  - FSM goes to IDLE; counters and pointers go to 0; the FIFO is emptied.
  - Synchroniser flops are set to 1.
  - All outputs read 0: `data` = 8'h00, `rx_ready` = `fifo_full` = `overrun` = `frame_error` = 0.
  - A partial frame in flight is discarded.

## Timing
- A falling edge on `rx` reaches `rx_s` 2 cycles later. The FSM leaves IDLE on the next edge.
- The start bit is verified CLKS_PER_BIT/2 cycles after detection. Each data bit is sampled CLKS_PER_BIT cycles after the previous sample.
- The stop bit is sampled in cycle S. The FIFO write is registered at the end of S, so `rx_ready`, `data` and `fifo_full` update in cycle S+1.
- `overrun` and `frame_error` assert in cycle S+1.
- Pop: with `read_en` high in cycle P, the next entry (or 8'h00 and `rx_ready` = 0) is visible in P+1. `data` in cycle P is the popped byte.
- `clear_errors` in cycle C clears the flags in C+1.
- All outputs are registered or decoded only from registered state; there is no combinational path from inputs to outputs.
- Throughput: continuous back-to-back frames at the nominal baud rate, with tolerance of about ±4% per frame.

## Test plan
Benches use CLKS_PER_BIT = 16 and FIFO_DEPTH = 4.

1. **Single byte:** drive frame 0xA5 → `rx_ready` = 1 and `data` = 0xA5 the cycle after the stop sample; pulse `read_en` → `rx_ready` = 0 and `data` = 0x00 the next cycle.
2. **Start glitch:** `rx` low for 4 cycles then high → FSM returns to IDLE; `rx_ready`, `frame_error` and `overrun` all remain 0.
3. **Overflow:** drive frames 0x01–0x05 back-to-back with no pops → `fifo_full` = 1 after 0x04 and `overrun` = 1 after 0x05; four pops return 0x01, 0x02, 0x03, 0x04, then `rx_ready` = 0.
4. **Framing error:** drive 0x3C with stop bit 0 → `frame_error` = 1 and `rx_ready` = 0; pulse `clear_errors` → `frame_error` = 0 the next cycle. A following valid 0x7E is received correctly.
5. **Simultaneous push and pop when full:** with the FIFO full of 0x10–0x13, assert `read_en` in the stop-sample cycle of 0x14 → `overrun` = 0, `fifo_full` stays 1, and subsequent pops give 0x11, 0x12, 0x13, 0x14.
6. **Reset mid-frame:** assert `rst` = 0 during DATA bit 3 of 0x99 with the FIFO holding 2 bytes → all outputs read 0 the next cycle. After release, frame 0x5A is received as the only byte.

Source files
------------

// File: rtl/uart_rx.sv
// 8N1 serial receiver with a show-ahead byte FIFO and sticky error flags.
// The line is synchronised, then sampled mid-bit by a single baud counter.
module uart_rx #(
    parameter int unsigned CLKS_PER_BIT = 868,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    input  logic       read_en,
    input  logic       clear_errors,
    output logic [7:0] data,
    output logic       rx_ready,
    output logic       fifo_full,
    output logic       overrun,
    output logic       frame_error
);

    localparam int unsigned CW = $clog2(CLKS_PER_BIT);
    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [PW:0]   DEPTH   = (PW + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t        state_q, state_d;
    logic [1:0]    sync_q, sync_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_idx_q, bit_idx_d;
    logic [7:0]    shift_q, shift_d;
    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [7:0]    mem_d [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PW:0]   count_q, count_d;
    logic          overrun_q, overrun_d, frame_error_q, frame_error_d;

    logic rx_s, push, stop_bad, pop, full, wr;

    assign rx_s = sync_q[1];
    assign full = (count_q == DEPTH);

    always_comb begin
        sync_d    = {sync_q[0], rx};
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        push      = 1'b0;
        stop_bad  = 1'b0;
        case (state_q)
            IDLE: begin
                if (!rx_s) begin
                    cnt_d   = HALF_M1;
                    state_d = START;
                end
            end
            START: begin
                if (cnt_q == '0) begin
                    if (!rx_s) begin
                        state_d   = DATA;
                        cnt_d     = FULL_M1;
                        bit_idx_d = '0;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            DATA: begin
                if (cnt_q == '0) begin
                    shift_d = {rx_s, shift_q[7:1]};
                    cnt_d   = FULL_M1;
                    if (bit_idx_q == 3'd7) begin
                        state_d = STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            STOP: begin
                // Sampling mid-stop and returning to IDLE at once leaves half a bit to catch the next start.
                if (cnt_q == '0) begin
                    push     = rx_s;
                    stop_bad = !rx_s;
                    state_d  = IDLE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        pop      = read_en && (count_q != '0);
        wr       = push && (!full || pop);
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (wr) begin
            mem_d[wr_ptr_q] = shift_q;
            wr_ptr_d        = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        count_d = count_q + (PW + 1)'(wr) - (PW + 1)'(pop);

        overrun_d     = clear_errors ? 1'b0 : overrun_q;
        frame_error_d = clear_errors ? 1'b0 : frame_error_q;
        if (push && full && !pop) overrun_d = 1'b1;
        if (stop_bad) frame_error_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q       <= IDLE;
            sync_q        <= 2'b11;
            cnt_q         <= '0;
            bit_idx_q     <= '0;
            shift_q       <= '0;
            mem_q         <= '{default: '0};
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            overrun_q     <= 1'b0;
            frame_error_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            sync_q        <= sync_d;
            cnt_q         <= cnt_d;
            bit_idx_q     <= bit_idx_d;
            shift_q       <= shift_d;
            mem_q         <= mem_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            overrun_q     <= overrun_d;
            frame_error_q <= frame_error_d;
        end
    end

    always_comb begin
        data        = (count_q != '0) ? mem_q[rd_ptr_q] : 8'h00;
        rx_ready    = (count_q != '0);
        fifo_full   = full;
        overrun     = overrun_q;
        frame_error = frame_error_q;
    end

endmodule
